// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter (CPU core and UART debug engine) in front of one synchronous SRAM port.
// Writes issue back-to-back; a read blocks the port until its data returns RD_LAT cycles later.
module mem_bus_arbiter #(
    parameter int AW       = 14,
    parameter int DW       = 32,
    parameter int RD_LAT   = 1,
    parameter int DBG_PRIO = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            c_req,
    input  logic            c_we,
    input  logic [DW/8-1:0] c_be,
    input  logic [AW-1:0]   c_addr,
    input  logic [DW-1:0]   c_wdata,
    output logic            c_gnt,
    output logic            c_rvalid,
    output logic [DW-1:0]   c_rdata,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [DW/8-1:0] d_be,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW-1:0]   d_wdata,
    output logic            d_gnt,
    output logic            d_rvalid,
    output logic [DW-1:0]   d_rdata,
    output logic            m_en,
    output logic            m_we,
    output logic [DW/8-1:0] m_be,
    output logic [AW-1:0]   m_addr,
    output logic [DW-1:0]   m_wdata,
    input  logic [DW-1:0]   m_rdata,
    output logic            state_dbg
);
    // Handshake: a transfer completes at the rising edge where x_req && x_gnt; x_rvalid is a
    // one-cycle pulse carrying read data, and x_gnt never rises without the matching x_req.

    typedef enum logic {IDLE = 1'b0, RD_WAIT = 1'b1} state_t;

    localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(RD_LAT - 1);
    localparam bit DBG_WINS = (DBG_PRIO != 0);

    state_t          state, state_nxt;
    logic [CW-1:0]   rd_cnt, rd_cnt_nxt;
    logic            rd_owner, rd_owner_nxt;        // 0 = core, 1 = debug
    logic            last_winner, last_winner_nxt;  // 0 = core, 1 = debug
    logic            pick_dbg;
    logic            win_we;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            rd_cnt      <= '0;
            rd_owner    <= 1'b0;
            last_winner <= 1'b1;
        end else begin
            state       <= state_nxt;
            rd_cnt      <= rd_cnt_nxt;
            rd_owner    <= rd_owner_nxt;
            last_winner <= last_winner_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        rd_cnt_nxt      = rd_cnt;
        rd_owner_nxt    = rd_owner;
        last_winner_nxt = last_winner;
        pick_dbg        = 1'b0;
        win_we          = 1'b0;
        c_gnt           = 1'b0;
        d_gnt           = 1'b0;
        c_rvalid        = 1'b0;
        d_rvalid        = 1'b0;
        c_rdata         = '0;
        d_rdata         = '0;
        m_en            = 1'b0;
        m_we            = 1'b0;
        m_be            = '0;
        m_addr          = '0;
        m_wdata         = '0;

        case (state)
            IDLE: begin
                if (c_req || d_req) begin
                    // Debug wins when alone, under debug priority, or when the core won last.
                    pick_dbg = d_req && (!c_req || DBG_WINS || !last_winner);
                    win_we   = pick_dbg ? d_we : c_we;
                    m_en     = 1'b1;
                    m_we     = win_we;
                    m_be     = pick_dbg ? d_be    : c_be;
                    m_addr   = pick_dbg ? d_addr  : c_addr;
                    m_wdata  = pick_dbg ? d_wdata : c_wdata;
                    d_gnt    = pick_dbg;
                    c_gnt    = !pick_dbg;
                    last_winner_nxt = pick_dbg;
                    if (!win_we) begin
                        rd_owner_nxt = pick_dbg;
                        rd_cnt_nxt   = CNT_INIT;
                        state_nxt    = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                if (rd_cnt == '0) begin
                    c_rvalid  = !rd_owner;
                    d_rvalid  = rd_owner;
                    c_rdata   = rd_owner ? '0 : m_rdata;
                    d_rdata   = rd_owner ? m_rdata : '0;
                    state_nxt = IDLE;
                end else begin
                    rd_cnt_nxt = rd_cnt - CW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Reset must silence the bus at once, not at the next edge.
        if (!rst) begin
            c_gnt    = 1'b0;
            d_gnt    = 1'b0;
            c_rvalid = 1'b0;
            d_rvalid = 1'b0;
            c_rdata  = '0;
            d_rdata  = '0;
            m_en     = 1'b0;
            m_we     = 1'b0;
            m_be     = '0;
            m_addr   = '0;
            m_wdata  = '0;
        end
    end

    assign state_dbg = (state == RD_WAIT);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: three instances (round-robin/lat 1, debug-prio/lat 1,
// round-robin/lat 2) share one stimulus; each has its own byte-enabled SRAM model.
module tb_mem_bus_arbiter;
    localparam int AW = 14;
    localparam int DW = 32;
    localparam int BW = DW / 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic          c_req, c_we, d_req, d_we;
    logic [BW-1:0] c_be, d_be;
    logic [AW-1:0] c_addr, d_addr;
    logic [DW-1:0] c_wdata, d_wdata;

    logic          c_gnt[3], c_rvalid[3], d_gnt[3], d_rvalid[3];
    logic [DW-1:0] c_rdata[3], d_rdata[3];
    logic          m_en[3], m_we[3], state_dbg[3];
    logic [BW-1:0] m_be[3];
    logic [AW-1:0] m_addr[3];
    logic [DW-1:0] m_wdata[3], m_rdata[3];

    int n_cmp = 0;
    int n_bad = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int LAT = (g == 2) ? 2 : 1;
        localparam int PRI = (g == 1) ? 1 : 0;

        mem_bus_arbiter #(.AW(AW), .DW(DW), .RD_LAT(LAT), .DBG_PRIO(PRI)) u_dut (
            .clk(clk), .rst(rst),
            .c_req(c_req), .c_we(c_we), .c_be(c_be), .c_addr(c_addr), .c_wdata(c_wdata),
            .c_gnt(c_gnt[g]), .c_rvalid(c_rvalid[g]), .c_rdata(c_rdata[g]),
            .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
            .d_gnt(d_gnt[g]), .d_rvalid(d_rvalid[g]), .d_rdata(d_rdata[g]),
            .m_en(m_en[g]), .m_we(m_we[g]), .m_be(m_be[g]), .m_addr(m_addr[g]),
            .m_wdata(m_wdata[g]), .m_rdata(m_rdata[g]), .state_dbg(state_dbg[g])
        );

        logic [DW-1:0] mem [0:255];
        logic [DW-1:0] p0, p1;
        always @(posedge clk) begin
            if (m_en[g]) begin
                if (m_we[g]) begin
                    for (int b = 0; b < BW; b++)
                        if (m_be[g][b]) mem[m_addr[g][7:0]][8*b +: 8] <= m_wdata[g][8*b +: 8];
                end else begin
                    p0 <= mem[m_addr[g][7:0]];
                end
            end
            p1 <= p0;
        end
        assign m_rdata[g] = (LAT == 2) ? p1 : p0;
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_c(input logic req, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] wd, input logic [BW-1:0] be = '1);
        c_req = req; c_we = we; c_addr = a; c_wdata = wd; c_be = be;
    endtask

    task automatic set_d(input logic req, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] wd, input logic [BW-1:0] be = '1);
        d_req = req; d_we = we; d_addr = a; d_wdata = wd; d_be = be;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        set_c(0, 0, '0, '0);
        set_d(0, 0, '0, '0);
        cyc();
        cyc();
        rst = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Requests high while in reset: everything must stay quiet.
        set_c(1, 1, 'h10, 'h1);
        set_d(1, 1, 'h20, 'h2);
        #2;
        check_val("rst_c_gnt", c_gnt[0], 0);
        check_val("rst_d_gnt", d_gnt[0], 0);
        check_val("rst_m_en", m_en[0], 0);
        check_val("rst_m_addr", m_addr[0], 0);
        check_val("rst_state", state_dbg[0], 0);
        cyc();
        rst = 1'b1;

        // Core-only write, partial-byte write, read back.
        set_c(1, 1, 'h10, 'hDEADBEEF);
        set_d(0, 0, '0, '0);
        #3;
        check_val("t1_wr_gnt", c_gnt[0], 1);
        check_val("t1_wr_men", m_en[0], 1);
        check_val("t1_wr_mwe", m_we[0], 1);
        check_val("t1_wr_addr", m_addr[0], 'h10);
        check_val("t1_wr_data", m_wdata[0], 'hDEADBEEF);
        check_val("t1_wr_dgnt", d_gnt[0], 0);
        cyc();
        set_c(1, 1, 'h10, 'h11223344, 4'h3);
        #3;
        check_val("t1_be_gnt", c_gnt[0], 1);
        check_val("t1_be_mbe", m_be[0], 'h3);
        cyc();
        set_c(1, 0, 'h10, '0);
        #3;
        check_val("t1_rd_gnt", c_gnt[0], 1);
        check_val("t1_rd_mwe", m_we[0], 0);
        cyc();
        set_c(0, 0, '0, '0);
        #3;
        check_val("t1_rvalid", c_rvalid[0], 1);
        check_val("t1_rdata", c_rdata[0], 'hDEAD3344);
        check_val("t1_d_rvalid", d_rvalid[0], 0);
        check_val("t1_d_rdata", d_rdata[0], 0);
        check_val("t1_wait_men", m_en[0], 0);
        cyc();
        #3;
        check_val("t1_rvalid_off", c_rvalid[0], 0);
        check_val("t1_rdata_off", c_rdata[0], 0);
        check_val("t1_state_idle", state_dbg[0], 0);

        // Continuous write contention: round-robin alternates from core; debug-prio holds debug.
        do_reset();
        set_c(1, 1, 'h20, 'hC0);
        set_d(1, 1, 'h30, 'hD0);
        for (int i = 0; i < 5; i++) begin
            #3;
            check_val("rr_c_gnt", c_gnt[0], (i % 2 == 0));
            check_val("rr_d_gnt", d_gnt[0], (i % 2 == 1));
            check_val("rr_addr", m_addr[0], (i % 2 == 0) ? 'h20 : 'h30);
            check_val("rr_men", m_en[0], 1);
            check_val("dp_d_gnt", d_gnt[1], 1);
            check_val("dp_c_gnt", c_gnt[1], 0);
            check_val("dp_addr", m_addr[1], 'h30);
            cyc();
        end
        set_d(0, 0, '0, '0);
        #3;
        check_val("dp_c_after", c_gnt[1], 1);
        check_val("dp_d_after", d_gnt[1], 0);
        check_val("rr_c_alone", c_gnt[0], 1);

        // RD_LAT=2: debug read blocks the core until after d_rvalid.
        do_reset();
        set_c(0, 0, '0, '0);
        set_d(1, 1, 'h40, 'hCAFEF00D);
        #3;
        check_val("t4_wr_dgnt", d_gnt[2], 1);
        cyc();
        set_d(1, 0, 'h40, '0);
        #3;
        check_val("t4_rd_dgnt", d_gnt[2], 1);
        check_val("t4_rd_mwe", m_we[2], 0);
        cyc();
        set_d(0, 0, '0, '0);
        set_c(1, 1, 'h50, 'h5);
        #3;
        check_val("t4_n1_cgnt", c_gnt[2], 0);
        check_val("t4_n1_men", m_en[2], 0);
        check_val("t4_n1_rvalid", d_rvalid[2], 0);
        check_val("t4_n1_state", state_dbg[2], 1);
        cyc();
        #3;
        check_val("t4_n2_cgnt", c_gnt[2], 0);
        check_val("t4_n2_rvalid", d_rvalid[2], 1);
        check_val("t4_n2_rdata", d_rdata[2], 'hCAFEF00D);
        check_val("t4_n2_c_rvalid", c_rvalid[2], 0);
        cyc();
        #3;
        check_val("t4_n3_cgnt", c_gnt[2], 1);
        check_val("t4_n3_rvalid", d_rvalid[2], 0);

        // Reset while a read is outstanding.
        do_reset();
        set_c(0, 0, '0, '0);
        set_d(1, 0, 'h40, '0);
        #3;
        check_val("t5_rd_dgnt", d_gnt[2], 1);
        cyc();
        set_c(1, 1, 'h60, 'h6);
        set_d(1, 1, 'h70, 'h7);
        #1;
        check_val("t5_live_rvalid", d_rvalid[0], 1);
        rst = 1'b0;
        #1;
        check_val("t5_kill_rvalid", d_rvalid[0], 0);
        check_val("t5_kill_rdata", d_rdata[0], 0);
        check_val("t5_kill_state", state_dbg[2], 0);
        check_val("t5_kill_men", m_en[2], 0);
        check_val("t5_kill_cgnt", c_gnt[2], 0);
        check_val("t5_kill_dgnt", d_gnt[2], 0);
        cyc();
        check_val("t5_hold_rvalid", d_rvalid[2], 0);
        cyc();
        rst = 1'b1;
        #3;
        check_val("t5_first_cgnt", c_gnt[2], 1);
        check_val("t5_first_dgnt", d_gnt[2], 0);
        check_val("t5_no_rvalid", d_rvalid[2], 0);
        cyc();
        #3;
        check_val("t5_second_dgnt", d_gnt[2], 1);
        check_val("t5_no_rvalid2", d_rvalid[2], 0);

        // Core request withdrawn during RD_WAIT never reaches the SRAM.
        do_reset();
        set_c(0, 0, '0, '0);
        set_d(1, 0, 'h40, '0);
        #3;
        check_val("t6_rd_dgnt", d_gnt[2], 1);
        cyc();
        set_d(0, 0, '0, '0);
        set_c(1, 1, 'h80, 'h8);
        #3;
        check_val("t6_w1_cgnt", c_gnt[2], 0);
        check_val("t6_w1_men", m_en[2], 0);
        cyc();
        set_c(0, 0, '0, '0);
        #3;
        check_val("t6_w2_cgnt", c_gnt[2], 0);
        check_val("t6_w2_men", m_en[2], 0);
        check_val("t6_w2_rvalid", d_rvalid[2], 1);
        cyc();
        #3;
        check_val("t6_idle_cgnt", c_gnt[2], 0);
        check_val("t6_idle_men", m_en[2], 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Two-requester arbiter sharing the single synchronous SRAM port between the CPU core (port c_) and the UART debug engine (port d_).
- Sits between both masters and sram, replacing direct core-to-SRAM wiring so the debugger can read and write memory over the same bus.
- Per-request valid/grant handshake. Read data returns after a fixed SRAM latency. Arbitration is round-robin or debug-priority, selected by parameter.

Parameters:
AW, 14, word address width of SRAM port
DW, 32, data width
RD_LAT, 1, SRAM read latency in cycles (>=1)
DBG_PRIO, 0, 0 = round-robin on contention; 1 = debug always wins contention

Ports:
clk  in  1  system clock, all logic rising-edge
rst  in  1  asynchronous, active-low reset
c_req  in  1  core request valid
c_we  in  1  core write enable (1 = write, 0 = read)
c_be  in  DW/8  core byte enables (writes)
c_addr  in  AW  core word address
c_wdata  in  DW  core write data
c_gnt  out  1  core request accepted this cycle
c_rvalid  out  1  core read data valid (1-cycle pulse)
c_rdata  out  DW  core read data
d_req, d_we, d_be, d_addr, d_wdata, d_gnt, d_rvalid, d_rdata  (same as c_*, debug side)
m_en  out  1  SRAM access strobe
m_we  out  1  SRAM write enable
m_be  out  DW/8  SRAM byte enables
m_addr  out  AW  SRAM address
m_wdata  out  DW  SRAM write data
m_rdata  in  DW  SRAM read data, valid RD_LAT cycles after m_en on a read

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, rd_cnt=0, rd_owner=core, last_winner=debug.
  - All outputs 0; m_en/gnt/rvalid are deasserted immediately, without waiting for a clock edge.
- FSM has two states, IDLE and RD_WAIT.
- IDLE, winner selection (combinational, same cycle):
  - Only one req high: that requester wins.
  - Both high, DBG_PRIO=1: debug wins.
  - Both high, DBG_PRIO=0: the requester that is not last_winner wins.
- IDLE, issue:
  - Winner's x_gnt=1. m_en=1 and m_we/m_be/m_addr/m_wdata are driven from the winner in the same cycle.
  - Transfer completes at the clock edge where req&gnt=1. last_winner is updated to the winner.
  - Write: stay IDLE; another grant is possible next cycle (1 write/cycle throughput).
  - Read: rd_owner:=winner, rd_cnt:=RD_LAT-1, go to RD_WAIT.
- IDLE, no req: m_en=0 and all m_* outputs are 0.
- RD_WAIT:
  - m_en=0, both gnt=0 (requests are held off).
  - rd_cnt decrements each cycle.
  - In the cycle rd_cnt==0: x_rvalid=1 for rd_owner only, x_rdata=m_rdata (combinational), then return to IDLE.
  - Read accepted at edge N → rvalid high in cycle N+RD_LAT. Next grant no earlier than cycle N+RD_LAT+1.
- x_rdata of the non-owner, and both x_rdata outside rvalid, are 0.
- Requesters may drop req before gnt (no lock, no penalty). Req signals are not registered inside the block.
- x_gnt is never asserted while x_req=0. c_gnt and d_gnt are never high together.
- DBG_PRIO=1 may starve the core indefinitely. This is intended: the debugger halts the core.
- Reset during RD_WAIT: the pending read is discarded, no rvalid is issued, and the FSM restarts in IDLE.
- Write and read to the same address by different masters are ordered by grant order; there is no forwarding.

Test Plan:
- Core only: write addr 0x010 data 0xDEADBEEF be=0xF → c_gnt=1 same cycle; m_en=1, m_we=1, m_addr=0x010. Then read 0x010 → c_rvalid 1 cycle later with c_rdata=0xDEADBEEF; d_rvalid stays 0.
- Contention, DBG_PRIO=0, both requesting writes continuously → grants alternate core, debug, core, debug… with the first grant after reset going to core; exactly one write per cycle.
- Contention, DBG_PRIO=1: both req for 5 cycles → d_gnt all 5 cycles, c_gnt=0; then d_req drops → c_gnt next cycle.
- Read blocking, RD_LAT=2: debug read at edge N while c_req held → c_gnt=0 in cycles N+1, N+2; d_rvalid in N+2; c_gnt in N+3.
- Reset mid-read: rst low in RD_WAIT cycle → all outputs 0 immediately, no rvalid after release, and the first contention after reset is granted to core.
- Withdrawn request: c_req high 1 cycle during RD_WAIT then low → no c_gnt, no SRAM access, m_en stays 0.
